// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared types and constants for the weight cache controller
package snn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FILL  = 2'd2,
    READY = 2'd3
  } state_e;

  localparam int SIZE_DATA = 8;
  localparam int SIZE_TILE = 4;
  localparam int LINE_W    = SIZE_DATA * SIZE_TILE;

  localparam logic [1:0] LAYER1 = 2'd1;
  localparam logic [1:0] LAYER2 = 2'd2;
  localparam logic [1:0] LAYER3 = 2'd3;

endpackage

// File: rtl/weight_cache_ram.sv
// rtl/weight_cache_ram.sv - single-port line cache with synchronous write and registered read
module weight_cache_ram
  import snn_pkg::*;
#(
  parameter int width  = LINE_W,
  parameter int addr_w = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [addr_w-1:0] addr,
  input  logic [width-1:0]  wdata,
  output logic [width-1:0]  rdata
);

  logic [width-1:0] mem [2**addr_w];
  logic [width-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/weight_cache_ctrl.sv
// rtl/weight_cache_ctrl.sv - fetches a weight layer into the line cache and serves reads
module weight_cache_ctrl
  import snn_pkg::*;
#(
  parameter int size_data            = 8,
  parameter int size_tile            = 4,
  parameter int size_addr_data_cache = 10,
  parameter int num_layers           = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            data_load,
  input  logic [1:0]                      layer_addr,
  input  logic [size_addr_data_cache-1:0] data_cache_addr,
  output logic                            memReady,
  output logic [size_data*size_tile-1:0]  data_line,
  output logic                            ext_req,
  output logic [1:0]                      ext_layer,
  input  logic                            ext_valid,
  output logic                            ext_ready,
  input  logic [size_data*size_tile-1:0]  ext_data,
  input  logic                            ext_last,
  output logic                            fill_error
);

  localparam int line_w = size_data * size_tile;
  localparam int aw     = size_addr_data_cache;
  localparam logic [aw:0] last_idx = (aw+1)'((2**aw) - 1);
  localparam logic [aw:0] one_c    = (aw+1)'(1);

  state_e      state_q, state_d;
  logic        data_load_q;
  logic [1:0]  ext_layer_q, ext_layer_d;
  logic        ext_req_q, ext_req_d;
  logic        ext_ready_q, ext_ready_d;
  logic        mem_ready_q, mem_ready_d;
  logic        fill_error_q, fill_error_d;
  logic        rd_en_q, rd_en_d;
  logic [aw:0] cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic [1:0]  pend_layer_q, pend_layer_d;

  logic              start, layer_ok, beat, ram_we;
  logic [aw-1:0]     ram_addr;
  logic [line_w-1:0] ram_rdata;

  always_comb begin
    state_d      = state_q;
    ext_layer_d  = ext_layer_q;
    fill_error_d = fill_error_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    pend_layer_d = pend_layer_q;
    ram_we       = 1'b0;
    start        = data_load & ~data_load_q;
    layer_ok     = (layer_addr >= LAYER1) && (int'(layer_addr) <= num_layers);
    beat         = ext_valid & ext_ready_q;

    case (state_q)
      IDLE, READY: begin
        if (start) begin
          if (layer_ok) begin
            ext_layer_d = layer_addr;
            state_d     = REQ;
          end else begin
            fill_error_d = 1'b1;
          end
        end
      end
      REQ, FILL: begin
        // A request arriving mid-fill is remembered and replayed once this fill ends.
        if (start) begin
          if (layer_ok) begin
            pend_d       = 1'b1;
            pend_layer_d = layer_addr;
          end else begin
            fill_error_d = 1'b1;
          end
        end
        if (state_q == REQ) begin
          cnt_d   = '0;
          state_d = FILL;
        end else if (beat) begin
          ram_we = ~cnt_q[aw];
          if (ext_last) begin
            if (cnt_q != last_idx) fill_error_d = 1'b1;
            if (pend_d) begin
              state_d     = REQ;
              ext_layer_d = pend_layer_d;
              pend_d      = 1'b0;
            end else begin
              state_d = READY;
            end
          end else if (!cnt_q[aw]) begin
            cnt_d = cnt_q + one_c;
            if (cnt_q == last_idx) fill_error_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    ext_req_d   = (state_d == REQ);
    ext_ready_d = (state_d == FILL);
    mem_ready_d = (state_d == READY);
    rd_en_d     = mem_ready_q;
    ram_addr    = (state_q == FILL) ? cnt_q[aw-1:0] : data_cache_addr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      data_load_q  <= 1'b0;
      ext_layer_q  <= '0;
      ext_req_q    <= 1'b0;
      ext_ready_q  <= 1'b0;
      mem_ready_q  <= 1'b0;
      fill_error_q <= 1'b0;
      rd_en_q      <= 1'b0;
      cnt_q        <= '0;
      pend_q       <= 1'b0;
      pend_layer_q <= '0;
    end else begin
      state_q      <= state_d;
      data_load_q  <= data_load;
      ext_layer_q  <= ext_layer_d;
      ext_req_q    <= ext_req_d;
      ext_ready_q  <= ext_ready_d;
      mem_ready_q  <= mem_ready_d;
      fill_error_q <= fill_error_d;
      rd_en_q      <= rd_en_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      pend_layer_q <= pend_layer_d;
    end
  end

  weight_cache_ram #(
    .width  (line_w),
    .addr_w (aw)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we & ~reset),
    .addr  (ram_addr),
    .wdata (ext_data),
    .rdata (ram_rdata)
  );

  assign memReady   = mem_ready_q;
  assign data_line  = rd_en_q ? ram_rdata : '0;
  assign ext_req    = ext_req_q;
  assign ext_layer  = ext_layer_q;
  assign ext_ready  = ext_ready_q;
  assign fill_error = fill_error_q;

endmodule

// File: tb/tb_weight_cache_ctrl.sv
// tb/tb_weight_cache_ctrl.sv - self-checking bench for weight_cache_ctrl
module tb_weight_cache_ctrl;
  import snn_pkg::*;

  localparam int AW    = 10;
  localparam int DEPTH = 1024;
  localparam int LW    = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          data_load = 1'b0;
  logic [1:0]    layer_addr = '0;
  logic [AW-1:0] data_cache_addr = '0;
  logic          ext_valid = 1'b0;
  logic          ext_last = 1'b0;
  logic [LW-1:0] ext_data = '0;
  logic          memReady, ext_req, ext_ready, fill_error;
  logic [1:0]    ext_layer;
  logic [LW-1:0] data_line;

  int checks = 0;
  int errors = 0;
  int req_cnt = 0;
  int beat_cnt = 0;

  always #5 clk = ~clk;

  weight_cache_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .data_load       (data_load),
    .layer_addr      (layer_addr),
    .data_cache_addr (data_cache_addr),
    .memReady        (memReady),
    .data_line       (data_line),
    .ext_req         (ext_req),
    .ext_layer       (ext_layer),
    .ext_valid       (ext_valid),
    .ext_ready       (ext_ready),
    .ext_data        (ext_data),
    .ext_last        (ext_last),
    .fill_error      (fill_error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: phase 0 = no fetch in flight, 1 = request issued, 2 = streaming.
  logic [LW-1:0] m_cache [DEPTH];
  int            m_phase = 0;
  int            m_layer = 0;
  int            m_pend_layer = 0;
  int            m_beats = 0;
  bit            m_ready = 0, m_err = 0, m_pend = 0, dl_prev = 0, chk_en = 0;
  logic [LW-1:0] m_line = '0;

  initial for (int i = 0; i < DEPTH; i++) m_cache[i] = '0;

  always @(posedge clk) begin : model
    logic [LW-1:0] nl;
    bit start, ok;
    if (reset) begin
      m_ready = 0; m_err = 0; m_pend = 0; dl_prev = 0;
      m_phase = 0; m_layer = 0; m_line = '0; chk_en = 1;
    end else begin
      nl    = m_ready ? m_cache[data_cache_addr] : '0;
      start = data_load && !dl_prev;
      ok    = (layer_addr != 2'd0) && (int'(layer_addr) <= 3);
      if (start && !ok) m_err = 1;
      if (m_phase == 0) begin
        if (start && ok) begin
          m_layer = int'(layer_addr); m_ready = 0; m_phase = 1;
        end
      end else begin
        if (start && ok) begin
          m_pend = 1; m_pend_layer = int'(layer_addr);
        end
        if (m_phase == 1) begin
          m_phase = 2; m_beats = 0;
        end else if (ext_valid) begin
          if (m_beats < DEPTH) m_cache[m_beats] = ext_data;
          if (ext_last) begin
            if (m_beats != DEPTH - 1) m_err = 1;
            if (m_pend) begin
              m_layer = m_pend_layer; m_pend = 0; m_phase = 1;
            end else begin
              m_ready = 1; m_phase = 0;
            end
          end else begin
            m_beats++;
            if (m_beats == DEPTH) m_err = 1;
          end
        end
      end
      dl_prev = data_load;
      m_line  = nl;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("memReady", memReady, m_ready);
      check("fill_error", fill_error, m_err);
      check("ext_req", ext_req, m_phase == 1);
      check("ext_ready", ext_ready, m_phase == 2);
      check("data_line", data_line, m_line);
      if (m_phase != 0) check("ext_layer", ext_layer, m_layer);
      if (ext_req === 1'b1) req_cnt++;
      if (ext_valid && ext_ready === 1'b1) beat_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; data_load = 1'b0; ext_valid = 1'b0; ext_last = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic start_load(input logic [1:0] l);
    layer_addr = l;
    data_load  = 1'b1;
    step();
    data_load  = 1'b0;
  endtask

  task automatic wait_fill();
    int n = 0;
    while (ext_ready !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    check("ready_timeout", ext_ready, 1);
  endtask

  // Feeds nbeats accepted beats; pend_at is a cycle index at which a new load request is raised.
  task automatic stream(input int nbeats, input int last_at, input bit toggle,
                        input logic [31:0] base, input int pend_at, input logic [1:0] pend_l);
    int i = 0;
    int cyc = 0;
    while (i < nbeats) begin
      ext_valid = !(toggle && (cyc % 2 == 1));
      ext_data  = base + 32'(i);
      ext_last  = ext_valid && (i == last_at);
      data_load = (cyc == pend_at);
      if (cyc == pend_at) layer_addr = pend_l;
      step();
      if (ext_valid) i++;
      cyc++;
    end
    ext_valid = 1'b0; ext_last = 1'b0; data_load = 1'b0;
  endtask

  task automatic read_at(input int a);
    data_cache_addr = AW'(a);
    step();
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int r0, b0;
    do_reset();
    check("rst_memReady", memReady, 0);
    check("rst_data_line", data_line, 0);
    check("rst_ext_req", ext_req, 0);
    check("rst_ext_layer", ext_layer, 0);
    check("rst_ext_ready", ext_ready, 0);
    check("rst_fill_error", fill_error, 0);

    // full layer 1 fill, data = index
    r0 = req_cnt;
    start_load(LAYER1);
    check("t1_req", ext_req, 1);
    check("t1_layer", ext_layer, 1);
    step();
    check("t1_req_once", ext_req, 0);
    wait_fill();
    b0 = beat_cnt;
    stream(1024, 1023, 1'b0, 32'h0, -1, 2'd0);
    check("t1_memReady", memReady, 1);
    check("t1_err", fill_error, 0);
    check("t1_beats", beat_cnt - b0, 1024);
    check("t1_req_count", req_cnt - r0, 1);
    read_at(5);
    check("t1_read5", data_line, 32'h5);

    // toggling valid, layer 2
    start_load(LAYER2);
    step();
    wait_fill();
    b0 = beat_cnt;
    stream(1024, 1023, 1'b1, 32'h2000_0000, -1, 2'd0);
    check("t2_beats", beat_cnt - b0, 1024);
    check("t2_memReady", memReady, 1);
    read_at(0);
    check("t2_read0", data_line, 32'h2000_0000);
    read_at(511);
    read_at(1023);
    check("t2_read1023", data_line, 32'h2000_03FF);

    // invalid layer while READY
    r0 = req_cnt;
    start_load(2'd0);
    check("t3_err", fill_error, 1);
    check("t3_memReady", memReady, 1);
    step(); step(); step();
    check("t3_no_req", req_cnt - r0, 0);
    check("t3_memReady_hold", memReady, 1);

    // request arriving mid-fill
    do_reset();
    r0 = req_cnt;
    start_load(LAYER1);
    step();
    wait_fill();
    stream(1024, 1023, 1'b0, 32'h1000_0000, 200, LAYER2);
    check("t4_no_memReady", memReady, 0);
    check("t4_second_req", ext_req, 1);
    check("t4_second_layer", ext_layer, 2);
    step();
    wait_fill();
    stream(1024, 1023, 1'b0, 32'h3000_0000, -1, 2'd0);
    check("t4_memReady", memReady, 1);
    check("t4_err", fill_error, 0);
    check("t4_req_count", req_cnt - r0, 2);

    // short burst: last on beat 100
    start_load(LAYER3);
    step();
    wait_fill();
    stream(101, 100, 1'b0, 32'h5000_0000, -1, 2'd0);
    check("t5_memReady", memReady, 1);
    check("t5_err", fill_error, 1);
    read_at(100);
    check("t5_read100", data_line, 32'h5000_0064);
    read_at(101);
    check("t5_stale101", data_line, 32'h3000_0065);

    // reset at beat 300, then a clean reload
    do_reset();
    start_load(LAYER1);
    step();
    wait_fill();
    stream(300, -1, 1'b0, 32'h7000_0000, -1, 2'd0);
    ext_valid = 1'b1;
    ext_data  = 32'h7000_012C;
    reset     = 1'b1;
    step();
    check("t6_memReady", memReady, 0);
    check("t6_ext_ready", ext_ready, 0);
    check("t6_ext_req", ext_req, 0);
    reset = 1'b0; ext_valid = 1'b0;
    step();
    start_load(LAYER2);
    step();
    wait_fill();
    stream(1024, 1023, 1'b0, 32'h8000_0000, -1, 2'd0);
    check("t6_reload_memReady", memReady, 1);
    check("t6_reload_err", fill_error, 0);
    read_at(300);
    check("t6_read300", data_line, 32'h8000_012C);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/weight_cache_ctrl.md
Name: weight_cache_ctrl

Overview:
- Synthesizable responder for the snn_top weight-fetch interface.
- snn_top requests a layer's weights by raising data_load with layer_addr. This block streams that layer's weight lines from external memory into an on-chip line cache, then raises memReady.
- While memReady is high it serves data_line for snn_top's data_cache_addr.
- Sits between snn_top and the external weight memory port, replacing the behavioural bench cache.

Parameters:
- size_data, 8, bits per weight
- size_tile, 4, weights per cache line; line width = size_data*size_tile
- size_addr_data_cache, 10, cache address width; depth = 2**size_addr_data_cache lines
- num_layers, 3, number of weight layers addressable via layer_addr (valid values 1..num_layers)

Ports:
- clk, input, 1, system clock
- reset, input, 1, synchronous active-high reset
- data_load, input, 1, load request from snn_top; a rising edge starts a load
- layer_addr, input, 2, layer to load; sampled on the data_load rising edge
- data_cache_addr, input, size_addr_data_cache, read address from snn_top
- memReady, output, 1, cache holds a complete layer and reads are valid
- data_line, output, size_data*size_tile, registered read data
- ext_req, output, 1, fetch request to external memory; a single-cycle pulse
- ext_layer, output, 2, layer being fetched; held stable from ext_req until the fill ends
- ext_valid, input, 1, external beat valid
- ext_ready, output, 1, block accepts a beat
- ext_data, input, size_data*size_tile, external beat payload
- ext_last, input, 1, marks the final beat of the layer
- fill_error, output, 1, sticky flag: ext_last and the beat count disagreed

Behaviour:
- Reset values: memReady=0, data_line=0, ext_req=0, ext_layer=0, ext_ready=0, fill_error=0.
  - The FSM goes to IDLE and the fill counter clears. Cache contents are undefined after reset.
- Reset wins over every other event in the same cycle, including mid-fill; the fill is abandoned.
- Edge detect: data_load is registered once; start = data_load & ~data_load_q.
- FSM states: IDLE, REQ, FILL, READY.
- IDLE / READY on start:
  - Capture layer_addr into ext_layer, go to REQ, clear memReady on the next edge.
  - If layer_addr is 0 or greater than num_layers: set fill_error, stay in the current state, memReady unchanged.
- REQ: ext_req=1 for exactly one cycle; fill counter = 0; next state FILL.
- FILL:
  - ext_ready=1. Each cycle with ext_valid & ext_ready writes ext_data to cache[counter] and increments counter.
  - On a beat with ext_last:
    - go to READY next cycle with memReady=1;
    - set fill_error if counter != depth-1 at that beat (short burst);
    - lines not written keep stale data.
  - If the counter wraps from depth-1 without ext_last: set fill_error, and further beats are still accepted but dropped (no write) until ext_last arrives.
- start during REQ/FILL: latched into a single pending bit together with its layer_addr; a later start overwrites the earlier pending one. After the fill completes the FSM goes to REQ instead of READY, and memReady stays 0.
- Reads:
  - data_line <= memReady ? cache[data_cache_addr] : 0, one-cycle latency.
  - The first valid data_line appears on the cycle after memReady rises, if the address is presented that cycle.
- fill_error clears only on reset.
- Width rule: the counter is size_addr_data_cache+1 bits so the wrap can be detected.

Decomposition:
- Shared package snn_pkg holds:
  - the state enum (IDLE, REQ, FILL, READY);
  - the line-width constant size_data*size_tile;
  - the layer-id constants LAYER1..LAYER3.
- One sub-module: weight_cache_ram, a single-port synchronous RAM with write enable and a registered read, depth 2**size_addr_data_cache.
  - Reads are ignored while the FSM is in FILL because memReady gates them; no read/write collision arbitration is required.

Test Plan:
- Reset, then data_load rise with layer_addr=1 -> exactly one ext_req cycle with ext_layer=1 and ext_ready=1. Feed 1024 beats with data=index and ext_last on beat 1023 -> memReady=1 the following cycle, fill_error=0. Read addr 5 -> data_line=32'h5 one cycle later.
- Fill with ext_valid toggling 50% -> beat count still 1024, and cache contents match the index pattern.
- ext_last on beat 100 -> memReady=1 and fill_error=1.
- data_load rise during FILL with layer_addr=2 -> after the current ext_last, no memReady. A second ext_req appears with ext_layer=2, and memReady rises only after that fill.
- data_load rise with layer_addr=0 while in READY -> fill_error=1, memReady stays 1, no ext_req.
- reset asserted at beat 300 of a fill -> next cycle memReady=0, ext_ready=0, state IDLE. A fresh load then completes normally.
